// File: rtl/axis_txfifo_burst_sched.sv
// axis_txfifo_burst_sched
// Drains an FWFT TX FIFO onto an AXI-Stream master port in fixed-length bursts.
// A burst starts only once the FIFO holds a full burst. The final beat carries TLAST,
// and a configurable idle gap follows each burst. Busy, a completed-burst counter and
// a sticky underrun flag are reported back to the register bank.
module axis_txfifo_burst_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 10,
    parameter int LEN_WIDTH   = 8,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cfg_enable,
    input  logic [LEN_WIDTH-1:0]   cfg_burst_len,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    input  logic                   status_clr,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_count,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic                   busy,
    output logic [15:0]            burst_count,
    output logic                   underrun
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_STREAM    = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    // Occupancy and burst length are compared at the wider of the two widths.
    localparam int CMP_WIDTH = (COUNT_WIDTH > LEN_WIDTH) ? COUNT_WIDTH : LEN_WIDTH;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [LEN_WIDTH-1:0]   r_len_q;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic [GAP_WIDTH-1:0]   r_gap_q;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic [15:0]            r_burst_count;
    logic                   r_underrun;

    logic [LEN_WIDTH-1:0]   w_eff_len;
    logic [LEN_WIDTH-1:0]   w_last_idx;
    logic                   w_data_ready;
    logic                   w_start;
    logic                   w_last_beat;
    logic                   w_handshake;
    logic                   w_burst_done;
    logic                   w_gap_done;

    // A zero length request is treated as a single-beat burst.
    assign w_eff_len    = (cfg_burst_len == '0) ? LEN_WIDTH'(1) : cfg_burst_len;
    assign w_data_ready = CMP_WIDTH'(fifo_count) >= CMP_WIDTH'(w_eff_len);
    assign w_start      = (r_state == S_WAIT_DATA) && cfg_enable && w_data_ready;

    // r_len_q is never zero while streaming, so the subtraction cannot wrap.
    assign w_last_idx   = r_len_q - LEN_WIDTH'(1);
    assign w_last_beat  = (r_beat_cnt == w_last_idx);

    // A pop of the FWFT head is exactly an accepted AXIS beat.
    assign w_handshake  = fifo_rd_en;
    assign w_burst_done = w_handshake && w_last_beat;

    // r_gap_q is non-zero whenever the FSM sits in GAP.
    assign w_gap_done   = (r_gap_cnt == (r_gap_q - GAP_WIDTH'(1)));

    // The FIFO head feeds the stream directly; it only moves on a pop, so it is stable under stall.
    assign M_AXIS_TDATA = fifo_dout;
    assign burst_count  = r_burst_count;
    assign underrun     = r_underrun;

    // State register.
    always_ff @(posedge ACLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: defaulting first keeps every path assigned, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_enable) begin
                    w_next_state = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (!cfg_enable) begin
                    w_next_state = S_IDLE;
                end else if (w_data_ready) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                // Dropping enable does not truncate a burst; it is checked only after TLAST.
                if (w_burst_done) begin
                    if (cfg_gap != '0) begin
                        w_next_state = S_GAP;
                    end else if (cfg_enable) begin
                        w_next_state = S_WAIT_DATA;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_next_state = cfg_enable ? S_WAIT_DATA : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: stream handshake and busy.
    always_comb begin
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        fifo_rd_en    = 1'b0;
        busy          = (r_state != S_IDLE);
        if (r_state == S_STREAM) begin
            M_AXIS_TVALID = !fifo_empty;
            M_AXIS_TLAST  = w_last_beat;
            fifo_rd_en    = !fifo_empty && M_AXIS_TREADY;
        end
    end

    // Burst bookkeeping: latched length, beat and gap counters, completed-burst counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_len_q       <= '0;
            r_beat_cnt    <= '0;
            r_gap_q       <= '0;
            r_gap_cnt     <= '0;
            r_burst_count <= '0;
        end else begin
            // Length is captured at burst start, so later config writes affect only the next burst.
            if (w_start) begin
                r_len_q    <= w_eff_len;
                r_beat_cnt <= '0;
            end
            if (w_handshake) begin
                r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            end
            // Gap is captured on the TLAST handshake; the counter wraps silently at 16 bits.
            if (w_burst_done) begin
                r_burst_count <= r_burst_count + 16'd1;
                r_gap_q       <= cfg_gap;
                r_gap_cnt     <= '0;
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_WIDTH'(1);
            end
        end
    end

    // Sticky underrun flag: an empty FIFO mid-burst sets it and wins over a coincident clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_underrun <= 1'b0;
        end else if ((r_state == S_STREAM) && fifo_empty) begin
            r_underrun <= 1'b1;
        end else if (status_clr) begin
            r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_txfifo_burst_sched.sv
// Testbench for axis_txfifo_burst_sched: per-cycle vector table plus hand-written
// sequences for reset mid-burst and the zero-length burst case. The FIFO is a
// bench-side FWFT model with a force-empty override.
module tb_axis_txfifo_burst_sched;

    localparam int DW = 32;
    localparam int CW = 10;
    localparam int LW = 8;
    localparam int GW = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cfg_enable;
    logic [LW-1:0] cfg_burst_len;
    logic [GW-1:0] cfg_gap;
    logic          status_clr;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic          busy;
    logic [15:0]   burst_count;
    logic          underrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    axis_txfifo_burst_sched #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW),
        .LEN_WIDTH  (LW),
        .GAP_WIDTH  (GW)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .cfg_enable   (cfg_enable),
        .cfg_burst_len(cfg_burst_len),
        .cfg_gap      (cfg_gap),
        .status_clr   (status_clr),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .busy         (busy),
        .burst_count  (burst_count),
        .underrun     (underrun)
    );

    // FWFT FIFO model; force_empty hides the contents to provoke an underrun.
    logic [DW-1:0] mem [0:255];
    logic [15:0]   wr_ptr = '0;
    logic [15:0]   rd_ptr = '0;
    logic          force_empty = 1'b0;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);
    assign fifo_count = CW'(wr_ptr - rd_ptr);
    assign fifo_dout  = mem[rd_ptr[7:0]];

    always @(posedge ACLK) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 16'd1;
    end

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Observation word: {valid, last, rd_en, busy, underrun, burst_count, data}.
    function automatic logic [63:0] obs(input logic v, input logic l, input logic rd, input logic b,
                                        input logic u, input logic [15:0] bc, input logic [31:0] d);
        return {11'd0, v, l, rd, b, u, bc, d};
    endfunction

    function automatic logic [63:0] dut_obs(input logic show_data);
        return obs(M_AXIS_TVALID, M_AXIS_TLAST, fifo_rd_en, busy, underrun, burst_count,
                   show_data ? M_AXIS_TDATA : 32'd0);
    endfunction

    typedef struct {
        logic        en;
        logic [7:0]  len;
        logic [7:0]  gap;
        logic        rdy;
        logic        push;
        logic [31:0] pd;
        logic        clr;
        logic        fe;
        logic        ev;
        logic        el;
        logic        erd;
        logic        eb;
        logic        eu;
        logic [15:0] ebc;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [7:0] len, input logic [7:0] gap, input logic rdy,
                       input logic push, input logic [31:0] pd, input logic clr, input logic fe,
                       input logic ev, input logic el, input logic erd, input logic eb, input logic eu,
                       input logic [15:0] ebc, input logic [31:0] ed);
        vec_t v;
        v.en = en; v.len = len; v.gap = gap; v.rdy = rdy; v.push = push; v.pd = pd;
        v.clr = clr; v.fe = fe; v.ev = ev; v.el = el; v.erd = erd; v.eb = eb; v.eu = eu;
        v.ebc = ebc; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!M_AXIS_TVALID && n < 10) begin
            @(negedge ACLK);
            #2;
            n++;
        end
        check(nm, 64'(M_AXIS_TVALID), 64'd1);
    endtask

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        ARESET        = 1'b1;
        cfg_enable    = 1'b0;
        cfg_burst_len = 8'd4;
        cfg_gap       = 8'd0;
        status_clr    = 1'b0;
        M_AXIS_TREADY = 1'b0;

        // Basic burst: len=4, gap=0.
        add(1,4,0,1,0,0,0,0, 0,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++) add(1,4,0,1,1,32'hA0 + 32'(k),0,0, 0,0,0,1,0,0,0);
        for (int k = 0; k < 4; k++) add(1,4,0,1,0,0,0,0, 1,(k == 3),1,1,0,0,32'hA0 + 32'(k));
        add(1,4,0,1,0,0,0,0, 0,0,0,1,0,1,0);

        // Threshold: 7 of 8 words must not start; the 8th starts next cycle.
        for (int k = 0; k < 7; k++) add(1,8,0,1,1,32'hB0 + 32'(k),0,0, 0,0,0,1,0,1,0);
        add(1,8,0,1,0,0,0,0, 0,0,0,1,0,1,0);
        add(1,8,0,1,1,32'hB7,0,0, 0,0,0,1,0,1,0);
        for (int k = 0; k < 8; k++) add(1,8,0,1,0,0,0,0, 1,(k == 7),1,1,0,1,32'hB0 + 32'(k));
        add(1,8,0,1,0,0,0,0, 0,0,0,1,0,2,0);

        // Gap of 5 between two 3-beat bursts, then one WAIT_DATA cycle.
        for (int k = 0; k < 6; k++) add(1,8,5,1,1,32'hC0 + 32'(k),0,0, 0,0,0,1,0,2,0);
        add(1,3,5,1,0,0,0,0, 0,0,0,1,0,2,0);
        for (int k = 0; k < 3; k++) add(1,3,5,1,0,0,0,0, 1,(k == 2),1,1,0,2,32'hC0 + 32'(k));
        for (int k = 0; k < 5; k++) add(1,3,5,1,0,0,0,0, 0,0,0,1,0,3,0);
        add(1,3,0,1,0,0,0,0, 0,0,0,1,0,3,0);
        for (int k = 0; k < 3; k++) add(1,3,0,1,0,0,0,0, 1,(k == 2),1,1,0,3,32'hC3 + 32'(k));
        add(1,3,0,1,0,0,0,0, 0,0,0,1,0,4,0);

        // Backpressure: TREADY 1,0,0,1 and a stall on the last beat.
        for (int k = 0; k < 4; k++) add(1,4,0,0,1,32'hD0 + 32'(k),0,0, 0,0,0,1,0,4,0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,4,32'hD0);
        add(1,4,0,0,0,0,0,0, 1,0,0,1,0,4,32'hD1);
        add(1,4,0,0,0,0,0,0, 1,0,0,1,0,4,32'hD1);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,4,32'hD1);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,4,32'hD2);
        add(1,4,0,0,0,0,0,0, 1,1,0,1,0,4,32'hD3);
        add(1,4,0,1,0,0,0,0, 1,1,1,1,0,4,32'hD3);
        add(1,4,0,1,0,0,0,0, 0,0,0,1,0,5,0);

        // Underrun after beat 2, resume, clear; then clear coincident with a new underrun.
        for (int k = 0; k < 4; k++) add(1,4,0,1,1,32'hE0 + 32'(k),0,0, 0,0,0,1,0,5,0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,5,32'hE0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,5,32'hE1);
        add(1,4,0,1,0,0,0,1, 0,0,0,1,0,5,0);
        add(1,4,0,1,0,0,0,1, 0,0,0,1,1,5,0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,1,5,32'hE2);
        add(1,4,0,1,0,0,0,0, 1,1,1,1,1,5,32'hE3);
        add(1,4,0,1,0,0,1,0, 0,0,0,1,1,6,0);
        for (int k = 0; k < 4; k++) add(1,4,0,1,1,32'hF0 + 32'(k),0,0, 0,0,0,1,0,6,0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,0,6,32'hF0);
        add(1,4,0,1,0,0,1,1, 0,0,0,1,0,6,0);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,1,6,32'hF1);
        add(1,4,0,1,0,0,0,0, 1,0,1,1,1,6,32'hF2);
        add(1,4,0,1,0,0,0,0, 1,1,1,1,1,6,32'hF3);
        add(1,4,0,1,0,0,1,0, 0,0,0,1,1,7,0);

        // Enable dropped at beat 2 of 8: burst completes, then IDLE.
        for (int k = 0; k < 8; k++) add(1,8,0,1,1,32'h60 + 32'(k),0,0, 0,0,0,1,0,7,0);
        add(1,8,0,1,0,0,0,0, 1,0,1,1,0,7,32'h60);
        for (int k = 1; k < 8; k++) add(0,8,0,1,0,0,0,0, 1,(k == 7),1,1,0,7,32'h60 + 32'(k));
        add(0,8,0,1,0,0,0,0, 0,0,0,0,0,8,0);
        add(0,8,0,1,0,0,0,0, 0,0,0,0,0,8,0);

        // Reset state.
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        #2;
        check("reset_state", dut_obs(1'b0), obs(0,0,0,0,0,16'd0,32'd0));

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge ACLK);
            cfg_enable    = v.en;
            cfg_burst_len = v.len;
            cfg_gap       = v.gap;
            M_AXIS_TREADY = v.rdy;
            status_clr    = v.clr;
            force_empty   = v.fe;
            if (v.push) push_word(v.pd);
            #2;
            check($sformatf("vec%0d", i), dut_obs(v.ev),
                  obs(v.ev, v.el, v.erd, v.eb, v.eu, v.ebc, v.ed));
        end

        // Reset mid-burst: aborts at once, FIFO contents untouched.
        @(negedge ACLK);
        status_clr    = 1'b0;
        force_empty   = 1'b0;
        cfg_enable    = 1'b1;
        cfg_burst_len = 8'd4;
        cfg_gap       = 8'd0;
        M_AXIS_TREADY = 1'b1;
        for (int k = 0; k < 4; k++) push_word(32'h1111_0000 + 32'(k));
        #2;
        wait_valid("rst_seq_start");
        check("rst_seq_beat0", dut_obs(1'b1), obs(1,0,1,1,0,16'd8,32'h1111_0000));
        @(negedge ACLK);
        M_AXIS_TREADY = 1'b0;
        #2;
        check("rst_seq_stall", dut_obs(1'b1), obs(1,0,0,1,0,16'd8,32'h1111_0001));
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        #2;
        check("rst_mid_burst", dut_obs(1'b0), obs(0,0,0,0,0,16'd0,32'd0));
        check("rst_fifo_untouched", 64'(wr_ptr - rd_ptr), 64'd3);

        // Remaining words stream as a fresh 3-beat burst after reset.
        @(negedge ACLK);
        ARESET        = 1'b0;
        cfg_burst_len = 8'd3;
        M_AXIS_TREADY = 1'b1;
        #2;
        wait_valid("post_rst_start");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge ACLK);
                #2;
            end
            check($sformatf("post_rst_beat%0d", k), dut_obs(1'b1),
                  obs(1,(k == 2),1,1,0,16'd0,32'h1111_0001 + 32'(k)));
        end
        @(negedge ACLK);
        #2;
        check("post_rst_done", dut_obs(1'b0), obs(0,0,0,1,0,16'd1,32'd0));

        // Zero length is treated as one beat.
        @(negedge ACLK);
        cfg_burst_len = 8'd0;
        push_word(32'h2222_0000);
        #2;
        wait_valid("len0_start");
        check("len0_beat", dut_obs(1'b1), obs(1,1,1,1,0,16'd1,32'h2222_0000));
        @(negedge ACLK);
        #2;
        check("len0_done", dut_obs(1'b0), obs(0,0,0,1,0,16'd2,32'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
